lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator that sits between the core's memory pipeline stage and the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data, read/write enables and byte-select port. Loads return the read data sign- or zero-extended through a single-cycle response pulse. Misaligned halfword/word accesses are either decomposed into byte beats or rejected, selected at compile time.

## Interface
Parameters:
- ADDR_LIMIT, 1024: data memory size in bytes; any byte of an access at or above this address is an error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load result when 1.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected; valid with resp_valid.
- data_addr  out  32  memory byte address.
- w_data_mem  out  32  memory write data.
- r_en_mem  out  1  memory read enable.
- w_en_mem  out  1  memory write enable.
- byte_sel  out  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes.
- r_data_mem  in  32  combinational read data, {addr+3, addr+2, addr+1, addr}.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. req_valid&&req_ready captures all req_* fields into registers.
  - Error check at capture: req_size=11, addr+bytes-1 >= ADDR_LIMIT, or (misaligned and macro absent) -> RESP with resp_err=1. No memory enable is ever asserted for an errored request.
  - Otherwise -> ACCESS, beat counter = 0.
- ACCESS, aligned (addr mod size = 0): one beat. data_addr=addr; byte_sel = 00/01/10 for byte/half/word; store drives w_en_mem=1 with w_data_mem=wdata; load drives r_en_mem=1 and captures r_data_mem at the closing edge. -> RESP.
- ACCESS, misaligned (macro present): N beats, N = 2 (half) or 4 (word). Beat k: data_addr=addr+k, byte_sel=00. Store: w_data_mem[7:0] = wdata byte k, other bits 0. Load: r_data_mem[7:0] goes to assembly lane k. -> RESP after beat N-1.
- RESP: resp_valid=1, req_ready=0. Load data is extended from bit 7 (byte) or bit 15 (half), per req_unsigned. Word loads pass through unchanged. -> IDLE.
- r_en_mem and w_en_mem are never high together. Both are 0 outside ACCESS. data_addr, w_data_mem and byte_sel are 0 outside ACCESS.
- Address arithmetic is 32-bit unsigned. The limit check must not wrap: 0xFFFFFFFF with size word is an error.

## Timing
- Reset: state IDLE; req_ready=1. All other outputs 0, internal registers 0.
- Reset asserted mid-ACCESS clears immediately: enables drop and no response is issued. Memory bytes already written by earlier beats remain; this is accepted.
- Aligned request accepted at edge T: ACCESS during cycle T..T+1, resp_valid high T+1..T+2, req_ready high again after T+2. Throughput is one aligned access per 3 cycles.
- Misaligned: ACCESS lasts N cycles, so response latency is N+1 cycles after acceptance.
- Error request: resp_valid is high in the cycle after acceptance.
- req_* inputs are ignored outside IDLE. There is no response back-pressure; the requester must take resp_valid when it is high.

## Configuration
- LSU_MISALIGN_EN defined: misaligned half/word accesses are split into byte beats as above.
- LSU_MISALIGN_EN undefined: misaligned half/word accesses return resp_err=1 with no memory access. Beat counter and assembly logic are compiled out.

## Test plan
- Reset: hold rst=0 -> req_ready=1, resp_valid=0, r_en_mem=w_en_mem=0, data_addr=0. Assert rst=0 asynchronously mid-ACCESS -> same values without waiting for a clock edge.
- Word store addr 0x10, data 0xDEADBEEF -> one cycle with w_en_mem=1, byte_sel=10, data_addr=0x10. Next cycle resp_valid=1, resp_err=0, resp_rdata=0. Memory bytes 0x10..0x13 = EF BE AD DE.
- Byte load addr 0x13, memory byte 0x80 -> signed gives resp_rdata=0xFFFFFF80; unsigned gives 0x00000080. Halfword load at 0x12 with bytes 34 F2, signed -> 0xFFFFF234.
- Word load addr 0x11 with memory bytes 0x11..0x14 = 01 02 03 04:
  - Macro on: four beats, data_addr 0x11..0x14, byte_sel=00, resp_rdata=0x04030201 five cycles after acceptance.
  - Macro off: resp_err=1 and r_en_mem never asserted.
- ADDR_LIMIT=1024, word load at 1022, and a request with req_size=11 -> resp_err=1, no enable asserted, resp_rdata=0.
- Back-to-back: req_valid held high with two stores queued -> second accepted only when req_ready returns. w_en_mem and r_en_mem never both 1 in any cycle.

Source files
------------

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator to byte-addressed data memory (option macro: LSU_MISALIGN_EN)
module lsu_mem_master #(
   parameter int unsigned ADDR_LIMIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] data_addr,
   output logic [31:0] w_data_mem,
   output logic        r_en_mem,
   output logic        w_en_mem,
   output logic [1:0]  byte_sel,
   input  logic [31:0] r_data_mem
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]  state;
   logic        q_we;
   logic [31:0] q_addr;
   logic [31:0] q_wdata;
   logic [1:0]  q_size;
   logic        q_uns;
   logic        q_err;
   logic [31:0] q_rdata;
`ifdef LSU_MISALIGN_EN
   logic        q_mis;
   logic [1:0]  beat;
   logic        last_beat;
`endif

   logic [1:0]  span;
   logic [32:0] last_byte;
   logic        misaligned;
   logic        req_bad;

   // Classify the incoming request; the end address is computed in 33 bits so it cannot wrap.
   always_comb begin
      span       = (req_size == 2'b10) ? 2'd3 : (req_size == 2'b01) ? 2'd1 : 2'd0;
      last_byte  = {1'b0, req_addr} + {31'b0, span};
      misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      req_bad    = (req_size == 2'b11) || (last_byte >= 33'(ADDR_LIMIT));
`ifndef LSU_MISALIGN_EN
      if (misaligned) req_bad = 1'b1;
`endif
   end

`ifdef LSU_MISALIGN_EN
   // Final byte beat: lane 1 for halfwords, lane 3 for words.
   always_comb begin
      last_beat = (beat == ((q_size == 2'b10) ? 2'd3 : 2'd1));
   end
`endif

   // Request capture, beat sequencing and load data collection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         q_we    <= 1'b0;
         q_addr  <= 32'd0;
         q_wdata <= 32'd0;
         q_size  <= 2'd0;
         q_uns   <= 1'b0;
         q_err   <= 1'b0;
         q_rdata <= 32'd0;
`ifdef LSU_MISALIGN_EN
         q_mis   <= 1'b0;
         beat    <= 2'd0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  q_we    <= req_we;
                  q_addr  <= req_addr;
                  q_wdata <= req_wdata;
                  q_size  <= req_size;
                  q_uns   <= req_unsigned;
                  q_err   <= req_bad;
                  q_rdata <= 32'd0;
`ifdef LSU_MISALIGN_EN
                  q_mis   <= misaligned;
                  beat    <= 2'd0;
`endif
                  state   <= req_bad ? S_RESP : S_ACCESS;
               end
            end
            S_ACCESS: begin
`ifdef LSU_MISALIGN_EN
               if (q_mis) begin
                  if (!q_we) q_rdata[{beat, 3'b000} +: 8] <= r_data_mem[7:0];
                  if (last_beat) state <= S_RESP;
                  else           beat  <= beat + 2'd1;
               end else
`endif
               begin
                  if (!q_we) q_rdata <= r_data_mem;
                  state <= S_RESP;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory port and response outputs decode straight from state so reset drops them at once.
   always_comb begin
      req_ready  = (state == S_IDLE);
      data_addr  = 32'd0;
      w_data_mem = 32'd0;
      r_en_mem   = 1'b0;
      w_en_mem   = 1'b0;
      byte_sel   = 2'b00;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'd0;
      if (state == S_ACCESS) begin
         r_en_mem   = !q_we;
         w_en_mem   = q_we;
         data_addr  = q_addr;
         byte_sel   = q_size;
         w_data_mem = q_we ? q_wdata : 32'd0;
`ifdef LSU_MISALIGN_EN
         if (q_mis) begin
            data_addr  = q_addr + {30'd0, beat};
            byte_sel   = 2'b00;
            w_data_mem = q_we ? {24'd0, q_wdata[{beat, 3'b000} +: 8]} : 32'd0;
         end
`endif
      end
      if (state == S_RESP) begin
         resp_valid = 1'b1;
         resp_err   = q_err;
         if (!q_we && !q_err) begin
            case (q_size)
               2'b00:   resp_rdata = {{24{!q_uns && q_rdata[7]}}, q_rdata[7:0]};
               2'b01:   resp_rdata = {{16{!q_uns && q_rdata[15]}}, q_rdata[15:0]};
               default: resp_rdata = q_rdata;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] data_addr;
   logic [31:0] w_data_mem;
   logic        r_en_mem;
   logic        w_en_mem;
   logic [1:0]  byte_sel;
   logic [31:0] r_data_mem;

   logic [7:0]  mem [0:1023];
   logic [9:0]  ma;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          both_cnt = 0;

   logic [31:0] r_rdata;
   logic        r_err;
   int          r_lat, r_nren, r_nwen;
   logic [31:0] r_afirst, r_alast;
   logic [1:0]  r_bs;
   int          rv_cnt;

   lsu_mem_master #(.ADDR_LIMIT(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .data_addr(data_addr), .w_data_mem(w_data_mem), .r_en_mem(r_en_mem),
      .w_en_mem(w_en_mem), .byte_sel(byte_sel), .r_data_mem(r_data_mem)
   );

   always #5 clk = ~clk;

   assign ma = data_addr[9:0];
   assign r_data_mem = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

   always @(posedge clk) begin
      if (w_en_mem) begin
         mem[ma] <= w_data_mem[7:0];
         if (byte_sel != 2'b00) mem[ma + 10'd1] <= w_data_mem[15:8];
         if (byte_sel == 2'b10) begin
            mem[ma + 10'd2] <= w_data_mem[23:16];
            mem[ma + 10'd3] <= w_data_mem[31:24];
         end
      end
   end

   always @(negedge clk) begin
      if (r_en_mem && w_en_mem) both_cnt = both_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input string tag);
      logic got;
      @(negedge clk);
      check_val({tag, "_ready_in"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0; r_lat = 0; r_nren = 0; r_nwen = 0;
      r_afirst = 32'd0; r_alast = 32'd0; r_bs = 2'b00; r_rdata = 32'd0; r_err = 1'b0;
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clk);
         if (r_en_mem || w_en_mem) begin
            if (r_nren + r_nwen == 0) begin
               r_afirst = data_addr;
               r_bs     = byte_sel;
            end
            r_alast = data_addr;
         end
         r_nren = r_nren + int'(r_en_mem);
         r_nwen = r_nwen + int'(w_en_mem);
         if (resp_valid) begin
            got = 1'b1; r_lat = c; r_rdata = resp_rdata; r_err = resp_err;
         end
      end
      if (!got) check_val({tag, "_resp_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      check_val({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      req_size = 2'b00; req_unsigned = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      check_val("rst_ready", 32'(req_ready), 32'd1);
      check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_val("rst_ren", 32'(r_en_mem), 32'd0);
      check_val("rst_wen", 32'(w_en_mem), 32'd0);
      check_val("rst_addr", data_addr, 32'd0);
      rst = 1'b1;

      run_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, "st_w");
      check_val("st_w_lat", 32'(r_lat), 32'd2);
      check_val("st_w_addr", r_afirst, 32'h10);
      check_val("st_w_bsel", 32'(r_bs), 32'd2);
      check_val("st_w_nwen", 32'(r_nwen), 32'd1);
      check_val("st_w_nren", 32'(r_nren), 32'd0);
      check_val("st_w_err", 32'(r_err), 32'd0);
      check_val("st_w_rdata", r_rdata, 32'd0);
      check_val("st_w_mem", {mem[32'h13], mem[32'h12], mem[32'h11], mem[32'h10]}, 32'hDEADBEEF);

      mem[32'h13] = 8'h80;
      run_req(1'b0, 32'h13, 32'd0, 2'b00, 1'b0, "ld_bs");
      check_val("ld_bs_data", r_rdata, 32'hFFFFFF80);
      check_val("ld_bs_bsel", 32'(r_bs), 32'd0);
      run_req(1'b0, 32'h13, 32'd0, 2'b00, 1'b1, "ld_bu");
      check_val("ld_bu_data", r_rdata, 32'h00000080);

      mem[32'h12] = 8'h34; mem[32'h13] = 8'hF2;
      run_req(1'b0, 32'h12, 32'd0, 2'b01, 1'b0, "ld_hs");
      check_val("ld_hs_data", r_rdata, 32'hFFFFF234);
      check_val("ld_hs_bsel", 32'(r_bs), 32'd1);
      check_val("ld_hs_nren", 32'(r_nren), 32'd1);
      run_req(1'b0, 32'h12, 32'd0, 2'b01, 1'b1, "ld_hu");
      check_val("ld_hu_data", r_rdata, 32'h0000F234);

      mem[32'h11] = 8'h01; mem[32'h12] = 8'h02; mem[32'h13] = 8'h03; mem[32'h14] = 8'h04;
      run_req(1'b0, 32'h11, 32'd0, 2'b10, 1'b0, "ld_wm");
`ifdef LSU_MISALIGN_EN
      check_val("ld_wm_lat", 32'(r_lat), 32'd5);
      check_val("ld_wm_data", r_rdata, 32'h04030201);
      check_val("ld_wm_err", 32'(r_err), 32'd0);
      check_val("ld_wm_nren", 32'(r_nren), 32'd4);
      check_val("ld_wm_afirst", r_afirst, 32'h11);
      check_val("ld_wm_alast", r_alast, 32'h14);
      check_val("ld_wm_bsel", 32'(r_bs), 32'd0);
`else
      check_val("ld_wm_lat", 32'(r_lat), 32'd1);
      check_val("ld_wm_err", 32'(r_err), 32'd1);
      check_val("ld_wm_nren", 32'(r_nren), 32'd0);
      check_val("ld_wm_data", r_rdata, 32'd0);
`endif

      run_req(1'b1, 32'h31, 32'h0000ABCD, 2'b01, 1'b0, "st_hm");
`ifdef LSU_MISALIGN_EN
      check_val("st_hm_lat", 32'(r_lat), 32'd3);
      check_val("st_hm_nwen", 32'(r_nwen), 32'd2);
      check_val("st_hm_mem", {16'd0, mem[32'h32], mem[32'h31]}, 32'h0000ABCD);
`else
      check_val("st_hm_err", 32'(r_err), 32'd1);
      check_val("st_hm_nwen", 32'(r_nwen), 32'd0);
      check_val("st_hm_mem", {16'd0, mem[32'h32], mem[32'h31]}, 32'h00000000);
`endif

      run_req(1'b0, 32'd1022, 32'd0, 2'b10, 1'b0, "lim_1022");
      check_val("lim_1022_err", 32'(r_err), 32'd1);
      check_val("lim_1022_en", 32'(r_nren + r_nwen), 32'd0);
      check_val("lim_1022_data", r_rdata, 32'd0);

      mem[1020] = 8'hA1; mem[1021] = 8'hB2; mem[1022] = 8'hC3; mem[1023] = 8'hD4;
      run_req(1'b0, 32'd1020, 32'd0, 2'b10, 1'b0, "lim_1020");
      check_val("lim_1020_err", 32'(r_err), 32'd0);
      check_val("lim_1020_data", r_rdata, 32'hD4C3B2A1);

      run_req(1'b0, 32'hFFFFFFFC, 32'd0, 2'b10, 1'b0, "wrap_fc");
      check_val("wrap_fc_err", 32'(r_err), 32'd1);
      check_val("wrap_fc_en", 32'(r_nren + r_nwen), 32'd0);
      run_req(1'b0, 32'hFFFFFFFF, 32'd0, 2'b10, 1'b0, "wrap_ff");
      check_val("wrap_ff_err", 32'(r_err), 32'd1);

      run_req(1'b1, 32'h0, 32'h12345678, 2'b11, 1'b0, "sz11");
      check_val("sz11_err", 32'(r_err), 32'd1);
      check_val("sz11_en", 32'(r_nren + r_nwen), 32'd0);
      check_val("sz11_data", r_rdata, 32'd0);
      check_val("sz11_lat", 32'(r_lat), 32'd1);
      check_val("sz11_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'd0);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11223344;
      req_size = 2'b10; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_addr = 32'h24; req_wdata = 32'h55667788;
      @(negedge clk);
      check_val("b2b_busy1", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_val("b2b_busy2", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_val("b2b_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_val("b2b_mem_a", {mem[32'h23], mem[32'h22], mem[32'h21], mem[32'h20]}, 32'h11223344);
      check_val("b2b_mem_b", {mem[32'h27], mem[32'h26], mem[32'h25], mem[32'h24]}, 32'h55667788);

      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      req_size = 2'b10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 check_val("ar_wen_before", 32'(w_en_mem), 32'd1);
      rst = 1'b0;
      #1;
      check_val("ar_wen", 32'(w_en_mem), 32'd0);
      check_val("ar_ren", 32'(r_en_mem), 32'd0);
      check_val("ar_addr", data_addr, 32'd0);
      check_val("ar_ready", 32'(req_ready), 32'd1);
      check_val("ar_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rv_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         rv_cnt = rv_cnt + int'(resp_valid);
      end
      check_val("ar_no_resp", 32'(rv_cnt), 32'd0);

      check_val("no_both_en", 32'(both_cnt), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
